arcade_input_mapper: RTL

- Parametrised keyboard/joystick-to-cabinet-button mapper that replaces hand-written scancode case statements in each core top.
- Decodes ps2_key toggle events against a runtime-loadable scancode table of NUM_BTN buttons × ALIASES codes.
- ORs in per-button joystick bits and stretches coin-type pulses.
- Drives an active-low button vector straight into the game core.

---
 rtl/arcade_input_mapper.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/arcade_input_mapper.sv
// ============================================================================
//  Module   : arcade_input_mapper
//  Brief    : PS/2 scancode + joystick to active-low cabinet button mapper.
//             Optional autofire gating when ARCADE_INPUT_AUTOFIRE_EN is defined.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module arcade_input_mapper #(
  parameter int NUM_BTN      = 8,
  parameter int ALIASES      = 2,
  parameter int NUM_PLAYERS  = 2,
  parameter int PULSE_CYCLES = 250000
) (
  input  logic                     clk_sys,
  input  logic                     RESET_L,
  input  logic [10:0]              ps2_key,
  input  logic [16*NUM_PLAYERS-1:0] joy_in,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_btn,
  input  logic [1:0]               cfg_alias,
  input  logic [8:0]               cfg_code,
  input  logic [6:0]               cfg_joy,
  input  logic [NUM_BTN-1:0]       pulse_mask,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic [NUM_BTN-1:0]       autofire_mask,
  input  logic [7:0]               autofire_div,
`endif
  output logic [NUM_BTN-1:0]       btn_n,
  output logic                     busy,
  output logic                     overflow
);

  localparam int c_BW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int c_AW = (ALIASES > 1) ? $clog2(ALIASES) : 1;
  localparam int c_PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int c_JW = 16 * NUM_PLAYERS;
  localparam logic [c_BW-1:0] c_LAST_BTN   = c_BW'(NUM_BTN - 1);
  localparam logic [c_AW-1:0] c_LAST_ALIAS = c_AW'(ALIASES - 1);
  localparam logic [c_PW-1:0] c_PLOAD      = c_PW'(PULSE_CYCLES - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  state_t            r_state, w_next;
  logic              r_armed, r_tog;
  logic              r_cur_pressed, r_pend_pressed, r_pend_valid;
  logic [8:0]        r_cur_code, r_pend_code;
  logic [c_BW-1:0]   r_sbtn;
  logic [c_AW-1:0]   r_salias;
  logic [8:0]        r_code [NUM_BTN][ALIASES];
  logic [6:0]        r_joy_cfg [NUM_BTN];
  logic [NUM_BTN-1:0] r_held, r_lvl_prev, r_btn_n;
  logic [NUM_BTN-1:0] w_hit, w_cfg_clr, w_lvl, w_active, w_out;
  logic [63:0]       w_joy_pad;
  logic              w_evt, w_last, w_start, w_from_pend, w_to_pend, w_drop, r_overflow;

  assign w_evt  = r_armed && (ps2_key[10] != r_tog);
  assign w_last = (r_sbtn == c_LAST_BTN) && (r_salias == c_LAST_ALIAS);

  always_ff @(posedge clk_sys or negedge RESET_L) begin
    if (!RESET_L) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_from_pend = 1'b0;
    w_to_pend   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_evt) begin
          w_next  = S_SCAN;
          w_start = 1'b1;
        end
      end
      S_SCAN: begin
        // On the final entry the pending slot frees up, so a same-cycle event is never lost
        if (w_last) begin
          if (r_pend_valid) begin
            w_from_pend = 1'b1;
            w_to_pend   = w_evt;
          end else if (w_evt) begin
            w_start = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end else if (w_evt) begin
          if (r_pend_valid) w_drop    = 1'b1;
          else              w_to_pend = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_L) begin
    if (!RESET_L) begin
      r_armed        <= 1'b0;
      r_tog          <= 1'b0;
      r_cur_pressed  <= 1'b0;
      r_cur_code     <= 9'h000;
      r_pend_valid   <= 1'b0;
      r_pend_pressed <= 1'b0;
      r_pend_code    <= 9'h000;
      r_overflow     <= 1'b0;
      r_sbtn         <= '0;
      r_salias       <= '0;
    end else begin
      r_armed <= 1'b1;
      r_tog   <= ps2_key[10];
      if (w_start) begin
        r_cur_pressed <= ps2_key[9];
        r_cur_code    <= ps2_key[8:0];
      end else if (w_from_pend) begin
        r_cur_pressed <= r_pend_pressed;
        r_cur_code    <= r_pend_code;
      end
      if (w_to_pend) begin
        r_pend_valid   <= 1'b1;
        r_pend_pressed <= ps2_key[9];
        r_pend_code    <= ps2_key[8:0];
      end else if (w_from_pend) begin
        r_pend_valid <= 1'b0;
      end
      if (w_drop) r_overflow <= 1'b1;
      if (w_start || w_from_pend) begin
        r_sbtn   <= '0;
        r_salias <= '0;
      end else if (r_state == S_SCAN) begin
        if (r_salias == c_LAST_ALIAS) begin
          r_salias <= '0;
          r_sbtn   <= r_sbtn + c_BW'(1);
        end else begin
          r_salias <= r_salias + c_AW'(1);
        end
      end
    end
  end

  always_comb begin
    w_hit     = '0;
    w_cfg_clr = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      w_cfg_clr[b] = cfg_we && (int'(cfg_btn) == b) && (int'(cfg_alias) < ALIASES);
      for (int a = 0; a < ALIASES; a++) begin
        if ((r_state == S_SCAN) && (int'(r_sbtn) == b) && (int'(r_salias) == a) &&
            (r_cur_code != 9'h000) && (r_code[b][a] == r_cur_code))
          w_hit[b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_L) begin
    if (!RESET_L) begin
      r_held     <= '0;
      r_lvl_prev <= '0;
      r_btn_n    <= '1;
      for (int b = 0; b < NUM_BTN; b++) begin
        r_joy_cfg[b] <= 7'h00;
        for (int a = 0; a < ALIASES; a++) r_code[b][a] <= 9'h000;
      end
    end else begin
      r_lvl_prev <= w_lvl;
      r_btn_n    <= ~w_out;
      for (int b = 0; b < NUM_BTN; b++) begin
        if (w_cfg_clr[b])  r_held[b] <= 1'b0;
        else if (w_hit[b]) r_held[b] <= r_cur_pressed;
        if (w_cfg_clr[b] && (cfg_alias == 2'd0)) r_joy_cfg[b] <= cfg_joy;
        for (int a = 0; a < ALIASES; a++) begin
          if (w_cfg_clr[b] && (int'(cfg_alias) == a)) r_code[b][a] <= cfg_code;
        end
      end
    end
  end

  // Unpopulated player slots read as zero
  if (NUM_PLAYERS < 4) begin : g_joy_pad
    assign w_joy_pad = {{(64 - c_JW){1'b0}}, joy_in};
  end else begin : g_joy_full
    assign w_joy_pad = joy_in[63:0];
  end

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    logic [c_PW-1:0] r_pcnt;

    assign w_lvl[b]    = r_held[b] | (r_joy_cfg[b][6] & w_joy_pad[r_joy_cfg[b][5:0]]);
    assign w_active[b] = w_lvl[b] | (pulse_mask[b] & (r_pcnt != '0));

    always_ff @(posedge clk_sys or negedge RESET_L) begin
      if (!RESET_L)                                         r_pcnt <= '0;
      else if (pulse_mask[b] && w_lvl[b] && !r_lvl_prev[b]) r_pcnt <= c_PLOAD;
      else if (r_pcnt != '0)                                r_pcnt <= r_pcnt - c_PW'(1);
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic        r_act_prev, r_af_phase;
    logic [19:0] r_af_cnt;
    logic        w_af_rise, w_af_on;

    assign w_af_rise = w_active[b] & ~r_act_prev;
    assign w_af_on   = autofire_mask[b] & ~pulse_mask[b] & (autofire_div != 8'd0);
    assign w_out[b]  = w_active[b] & (~w_af_on | w_af_rise | r_af_phase);

    // Counter restarts at 1 so the first high half lasts exactly div*4096 cycles
    always_ff @(posedge clk_sys or negedge RESET_L) begin
      if (!RESET_L) begin
        r_act_prev <= 1'b0;
        r_af_phase <= 1'b1;
        r_af_cnt   <= 20'd0;
      end else begin
        r_act_prev <= w_active[b];
        if (w_af_rise) begin
          r_af_cnt   <= 20'd1;
          r_af_phase <= 1'b1;
        end else if (r_af_cnt >= ({autofire_div, 12'h000} - 20'd1)) begin
          r_af_cnt   <= 20'd0;
          r_af_phase <= ~r_af_phase;
        end else begin
          r_af_cnt <= r_af_cnt + 20'd1;
        end
      end
    end
`else
    assign w_out[b] = w_active[b];
`endif
  end

  assign btn_n    = r_btn_n;
  assign busy     = (r_state == S_SCAN);
  assign overflow = r_overflow;

endmodule

`default_nettype wire
